// File: rtl/dpm_qreg.sv
// Q register of the DPM datapath: size-aware shift register plus mul/div iteration counter.
// Optional even-parity output q_par_h when DPM_QREG_PARITY_EN is defined.
module dpm_qreg #(
  parameter int unsigned QW  = 32,
  parameter int unsigned LCW = 6
) (
  input  logic           clk,
  input  logic           reset_l,
  input  logic           q_en_h,
  input  logic           q_load_l,
  input  logic           dq_q_shl_l,
  input  logic           dq_q_shr_l,
  input  logic [1:0]     dsize_h,
  input  logic           q_sin_h,
  input  logic [QW-1:0]  wbus_h,
  input  logic           loop_load_h,
  input  logic [LCW-1:0] loop_cnt_h,
  input  logic           loop_dec_h,
  output logic [QW-1:0]  q_h,
  output logic           q_sout_shl_h,
  output logic           q_sout_shr_h,
  output logic           loopf_h
`ifdef DPM_QREG_PARITY_EN
  ,
  output logic           q_par_h
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  logic [QW-1:0]  size_mask;
  logic [QW-1:0]  top_bit;
  logic [QW-1:0]  q_shl;
  logic [QW-1:0]  q_shr;
  logic [QW-1:0]  q_next;
  logic [LCW-1:0] count;
  logic [LCW-1:0] count_next;

  // Operand-size window; top_bit marks bit [size-1].
  always_comb begin
    size_mask = '1;
    case (dsize_h)
      2'b00:   size_mask = QW'({BYTE_W{1'b1}});
      2'b01:   size_mask = QW'({WORD_W{1'b1}});
      default: size_mask = '1;
    endcase
    top_bit = size_mask ^ (size_mask >> 1);
  end

  // Shifts only touch bits inside the size window.
  always_comb begin
    q_shl = (q_h & ~size_mask) | (((q_h << 1) | QW'(q_sin_h)) & size_mask);
    q_shr = (q_h & ~size_mask)
          | ((((q_h & size_mask) >> 1) | (q_sin_h ? top_bit : '0)) & size_mask);
  end

  // Q next state: load > shift > hold; both shift lines asserted is a no-op.
  always_comb begin
    q_next = q_h;
    if (q_en_h) begin
      if (!q_load_l) begin
        q_next = wbus_h;
      end else if (!dq_q_shl_l && dq_q_shr_l) begin
        q_next = q_shl;
      end else if (dq_q_shl_l && !dq_q_shr_l) begin
        q_next = q_shr;
      end
    end
  end

  // Iteration counter: load wins over decrement, decrement saturates at zero.
  always_comb begin
    count_next = count;
    if (q_en_h) begin
      if (loop_load_h) begin
        count_next = loop_cnt_h;
      end else if (loop_dec_h && (count != '0)) begin
        count_next = count - LCW'(1);
      end
    end
  end

  // Shift-outs depend only on registered Q and dsize, never on q_sin_h.
  assign q_sout_shl_h = |(q_h & top_bit);
  assign q_sout_shr_h = q_h[0];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      q_h     <= '0;
      count   <= '0;
      loopf_h <= 1'b0;
    end else begin
      q_h     <= q_next;
      count   <= count_next;
      loopf_h <= (count_next != '0);
    end
  end

`ifdef DPM_QREG_PARITY_EN
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      q_par_h <= 1'b0;
    end else begin
      q_par_h <= ^q_next;
    end
  end
`endif

endmodule

// File: tb/tb_dpm_qreg.sv
// Self-checking bench for dpm_qreg: directed vector table, hand sequences and
// randomized traffic against an arithmetic reference model.
module tb_dpm_qreg;

  logic        clk;
  logic        reset_l;
  logic        q_en_h;
  logic        q_load_l;
  logic        dq_q_shl_l;
  logic        dq_q_shr_l;
  logic [1:0]  dsize_h;
  logic        q_sin_h;
  logic [31:0] wbus_h;
  logic        loop_load_h;
  logic [5:0]  loop_cnt_h;
  logic        loop_dec_h;
  logic [31:0] q_h;
  logic        q_sout_shl_h;
  logic        q_sout_shr_h;
  logic        loopf_h;
`ifdef DPM_QREG_PARITY_EN
  logic        q_par_h;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] q_m;
  int          cnt_m;

  dpm_qreg #(.QW(32), .LCW(6)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .q_en_h       (q_en_h),
    .q_load_l     (q_load_l),
    .dq_q_shl_l   (dq_q_shl_l),
    .dq_q_shr_l   (dq_q_shr_l),
    .dsize_h      (dsize_h),
    .q_sin_h      (q_sin_h),
    .wbus_h       (wbus_h),
    .loop_load_h  (loop_load_h),
    .loop_cnt_h   (loop_cnt_h),
    .loop_dec_h   (loop_dec_h),
    .q_h          (q_h),
    .q_sout_shl_h (q_sout_shl_h),
    .q_sout_shr_h (q_sout_shr_h),
    .loopf_h      (loopf_h)
`ifdef DPM_QREG_PARITY_EN
    ,
    .q_par_h      (q_par_h)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [1:0] ds);
    return (ds == 2'd0) ? 8 : (ds == 2'd1) ? 16 : 32;
  endfunction

  // Shift modelled as arithmetic on the low 'size' bits treated as a number.
  function automatic logic [31:0] m_shl(input logic [31:0] q, input logic [1:0] ds, input logic sin);
    longint unsigned m, low, hi;
    m   = 64'd1 << size_of(ds);
    low = longint'(q) % m;
    hi  = longint'(q) - low;
    low = (low * 2 + longint'(sin)) % m;
    return 32'(hi + low);
  endfunction

  function automatic logic [31:0] m_shr(input logic [31:0] q, input logic [1:0] ds, input logic sin);
    longint unsigned m, low, hi;
    m   = 64'd1 << size_of(ds);
    low = longint'(q) % m;
    hi  = longint'(q) - low;
    low = low / 2 + longint'(sin) * (m / 2);
    return 32'(hi + low);
  endfunction

  function automatic logic m_sout_shl(input logic [31:0] q, input logic [1:0] ds);
    longint unsigned v;
    v = (longint'(q) >> (size_of(ds) - 1)) % 2;
    return v[0];
  endfunction

  task automatic model_step();
    if (q_en_h) begin
      if (!q_load_l)                       q_m = wbus_h;
      else if (!dq_q_shl_l && dq_q_shr_l)  q_m = m_shl(q_m, dsize_h, q_sin_h);
      else if (dq_q_shl_l && !dq_q_shr_l)  q_m = m_shr(q_m, dsize_h, q_sin_h);
      if (loop_load_h)                     cnt_m = int'(loop_cnt_h);
      else if (loop_dec_h && cnt_m > 0)    cnt_m = cnt_m - 1;
    end
  endtask

  // One clock: check comb shift-outs before the edge, then registered state after.
  task automatic cyc();
    #1;
    chk("sout_shl_pre", 32'(q_sout_shl_h), 32'(m_sout_shl(q_m, dsize_h)));
    chk("sout_shr_pre", 32'(q_sout_shr_h), 32'(q_m[0]));
    @(posedge clk);
    model_step();
    #1;
    chk("q", q_h, q_m);
    chk("loopf", 32'(loopf_h), 32'(cnt_m != 0));
`ifdef DPM_QREG_PARITY_EN
    chk("par", 32'(q_par_h), 32'($countones(q_m) % 2));
`endif
  endtask

  task automatic idle();
    q_en_h = 1'b1; q_load_l = 1'b1; dq_q_shl_l = 1'b1; dq_q_shr_l = 1'b1;
    dsize_h = 2'b10; q_sin_h = 1'b0; wbus_h = '0;
    loop_load_h = 1'b0; loop_cnt_h = '0; loop_dec_h = 1'b0;
  endtask

  typedef struct {
    logic        load_l;
    logic        shl_l;
    logic        shr_l;
    logic [1:0]  dsize;
    logic        sin;
    logic [31:0] wbus;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs[10];
  int   en_pat[5];
  int   lf_pat[5];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0001, 32'h8000_0001};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 32'h0,         32'h0000_0003};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h1234_5681, 32'h1234_5681};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0,         32'h1234_56C0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'hFFFF_0000, 32'hFFFF_0000};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h0,         32'hFFFF_0000};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_A5A5, 32'h0000_A5A5};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0,         32'h0000_4B4A};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0,         32'h0000_A5A5};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0,         32'h0000_52D2};
    en_pat = '{1, 0, 1, 1, 1};
    lf_pat = '{1, 1, 1, 1, 0};

    idle();
    reset_l = 1'b0;
    q_m = '0; cnt_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", q_h, 32'h0);
    chk("reset_loopf", 32'(loopf_h), 32'h0);
    chk("reset_sout_shl", 32'(q_sout_shl_h), 32'h0);
    chk("reset_sout_shr", 32'(q_sout_shr_h), 32'h0);
    reset_l = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      idle();
      q_load_l = vecs[i].load_l; dq_q_shl_l = vecs[i].shl_l; dq_q_shr_l = vecs[i].shr_l;
      dsize_h = vecs[i].dsize; q_sin_h = vecs[i].sin; wbus_h = vecs[i].wbus;
      if (i == 1) begin
        #1;
        chk("v1_pre_sout_shl", 32'(q_sout_shl_h), 32'h1);
        chk("v1_pre_sout_shr", 32'(q_sout_shr_h), 32'h1);
      end
      if (i == 3) begin
        #1;
        chk("v3_pre_sout_shr", 32'(q_sout_shr_h), 32'h1);
      end
      cyc();
      chk($sformatf("vec%0d", i), q_h, vecs[i].exp_q);
    end

    // Word shift-left x16 with zero fill pushes the window empty; upper half untouched
    idle(); q_load_l = 1'b0; wbus_h = 32'hFFFF_0000; cyc();
    idle(); dsize_h = 2'b01; dq_q_shl_l = 1'b0; q_sin_h = 1'b0;
    for (int i = 0; i < 16; i++) cyc();
    chk("word_shl16", q_h, 32'hFFFF_0000);
    idle(); q_load_l = 1'b0; wbus_h = 32'hFFFF_00FF; cyc();
    idle(); dsize_h = 2'b01; dq_q_shl_l = 1'b0; q_sin_h = 1'b0;
    for (int i = 0; i < 16; i++) cyc();
    chk("word_shl16_b", q_h, 32'hFFFF_0000);

    // Stall holds Q
    idle(); q_en_h = 1'b0; q_load_l = 1'b0; wbus_h = 32'h1111_1111; cyc();
    chk("stall_hold", q_h, 32'hFFFF_0000);

    // Iteration counter: load 3, decrement x5 with enable pattern
    idle(); loop_load_h = 1'b1; loop_cnt_h = 6'd3; cyc();
    idle(); loop_dec_h = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q_en_h = (en_pat[i] != 0);
      #1;
      chk($sformatf("loop_pre%0d", i), 32'(loopf_h), 32'(lf_pat[i]));
      cyc();
    end
    chk("loop_sat", 32'(loopf_h), 32'h0);
    idle(); loop_load_h = 1'b1; loop_dec_h = 1'b1; loop_cnt_h = 6'd2; cyc();
    idle(); loop_dec_h = 1'b1; cyc();
    chk("load_beats_dec", 32'(loopf_h), 32'h1);
    cyc();
    chk("load_beats_dec_end", 32'(loopf_h), 32'h0);
    idle(); loop_load_h = 1'b1; loop_cnt_h = 6'd0; cyc();
    chk("load_zero", 32'(loopf_h), 32'h0);

`ifdef DPM_QREG_PARITY_EN
    idle(); q_load_l = 1'b0; wbus_h = 32'h0000_0007; cyc();
    chk("par_7", 32'(q_par_h), 32'h1);
    idle(); dq_q_shl_l = 1'b0; q_sin_h = 1'b0; cyc();
    chk("par_e_q", q_h, 32'h0000_000E);
    chk("par_e", 32'(q_par_h), 32'h1);
    idle(); q_load_l = 1'b0; wbus_h = 32'h0000_0003; cyc();
    chk("par_3", 32'(q_par_h), 32'h0);
`endif

    // Asynchronous reset mid-cycle, mid-loop
    idle(); q_load_l = 1'b0; wbus_h = 32'hDEAD_BEEF; loop_load_h = 1'b1; loop_cnt_h = 6'd5; cyc();
    chk("pre_reset_q", q_h, 32'hDEAD_BEEF);
    idle();
    @(negedge clk); #2;
    reset_l = 1'b0;
    #1;
    chk("async_reset_q", q_h, 32'h0);
    chk("async_reset_loopf", 32'(loopf_h), 32'h0);
    q_m = '0; cnt_m = 0;
    @(posedge clk); #1;
    reset_l = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      q_en_h      = ($urandom_range(0, 7) != 0);
      q_load_l    = ($urandom_range(0, 7) != 0);
      dq_q_shl_l  = 1'($urandom_range(0, 1));
      dq_q_shr_l  = 1'($urandom_range(0, 1));
      dsize_h     = 2'($urandom_range(0, 3));
      q_sin_h     = 1'($urandom_range(0, 1));
      wbus_h      = $urandom;
      loop_load_h = ($urandom_range(0, 9) == 0);
      loop_cnt_h  = 6'($urandom_range(0, 7));
      loop_dec_h  = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpm_qreg.md
Name: dpm_qreg

Overview:
- Q register of the DPM datapath: a 32-bit register with size-aware left/right shifter and a multiply/divide iteration counter.
- Sits directly downstream of the Q shift-in multiplexer and consumes its q_sin_h output as the shift-in bit.
- Produces the Q shift-out bits and LOOPF, which feed back into that multiplexer.

Parameters:
QW, 32, Q register width in bits (fixed 32 for VAX; byte/word/long sizes derive from it).
LCW, 6, iteration counter width in bits.

Ports:
clk  input  1  datapath clock; all state updates on rising edge.
reset_l  input  1  asynchronous active-low reset.
q_en_h  input  1  cycle enable (0 = stall; all state holds).
q_load_l  input  1  load Q from WBUS.
dq_q_shl_l  input  1  DQ field specifies Q shift left.
dq_q_shr_l  input  1  DQ field specifies Q shift right.
dsize_h  input  2  data length: 00 byte, 01 word, 10/11 long.
q_sin_h  input  1  shift-in bit from the Q shift-in mux.
wbus_h  input  QW  WBUS data for load.
loop_load_h  input  1  load iteration counter.
loop_cnt_h  input  LCW  iteration count to load.
loop_dec_h  input  1  decrement iteration counter.
q_h  output  QW  Q register contents.
q_sout_shl_h  output  1  Q bit [size-1] (left shift-out).
q_sout_shr_h  output  1  Q bit 0 (right shift-out).
loopf_h  output  1  loop flag, 1 while counter nonzero.

Behaviour:
- Reset (reset_l=0, asynchronous): q_h=0, counter=0, loopf_h=0. Shift-outs are therefore 0. Reset mid-shift or mid-loop aborts immediately; on release the block idles until the next load.
- q_en_h=0: Q and counter hold regardless of other inputs.
- Q update priority when q_en_h=1: load > shift > hold.
  - q_load_l=0: q_h <= wbus_h (full QW bits, independent of dsize_h).
  - Else, only dq_q_shl_l=0: shift left within size. Bits [size-1:1] <= [size-2:0]; bit0 <= q_sin_h.
  - Else, only dq_q_shr_l=0: shift right within size. Bits [size-2:0] <= [size-1:1]; bit[size-1] <= q_sin_h.
  - Both shift lines asserted: hold (illegal microcode, no-op).
  - Size is 8/16/32 for byte/word/long. Bits at and above the size are never modified by a shift.
- q_sout_shl_h = q_h[size-1] and q_sout_shr_h = q_h[0]. Both are combinational from registered Q and current dsize_h, so they are valid in the same cycle for the mux to compute q_sin_h.
- No combinational path from q_sin_h to any output (breaks the mux feedback loop).
- Iteration counter, updated when q_en_h=1:
  - loop_load_h=1: count <= loop_cnt_h. Load wins over decrement.
  - Else loop_dec_h=1 and count!=0: count <= count-1.
  - Decrement at 0 saturates at 0; no wrap.
- loopf_h = (count != 0), registered-derived. Load of 0 gives loopf_h=0 next cycle.
- Shift and counter are independent; simultaneous shift and decrement is normal multiply-step operation.

Optional Feature:
- Macro: DPM_QREG_PARITY_EN.
- Defined:
  - Extra output q_par_h (1 bit), even parity over all QW bits of q_h.
  - Registered alongside Q: computed from next-state Q and updated on the same edge.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset with q_h loaded 0xDEADBEEF, then reset_l=0 mid-cycle -> q_h=0, loopf_h=0 immediately, without a clock edge.
- Load 0x80000001, dsize=long, shl, q_sin_h=1 -> q_h=0x00000003; before the edge q_sout_shl_h=1 and q_sout_shr_h=1.
- Load 0x12345681, dsize=byte, shr, q_sin_h=1 -> q_h=0x123456C0; upper 24 bits unchanged; q_sout_shr_h was 1.
- Load 0xFFFF0000, dsize=word, shl ×16 with q_sin_h=0 -> q_h=0xFFFF0000; shr with dq both asserted -> hold.
- loop_cnt=3, load, then dec ×5 with q_en_h toggling 1,0,1,1,1 -> loopf_h 1,1,1,1,0 and count stays 0; load and dec same cycle -> loaded value.
- With DPM_QREG_PARITY_EN: load 0x00000007 -> q_par_h=1; shl with q_sin_h=0 -> 0x0000000E, q_par_h=1; load 0x3 -> q_par_h=0.
